// File: rtl/load_block_2d_if.sv
// DMA read-beat bus between the block loader (master) and the DMA engine (slave).
// One request cycle per beat; dmaOut carries BEAT_WORDS words, word i at [i*DATA_W +: DATA_W].
interface load_block_2d_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int BEAT_WORDS = 25
);
  logic                         dmaEnable;
  logic                         dmaRW;
  logic [ADDR_W-1:0]            dmaAddr;
  logic [DATA_W*BEAT_WORDS-1:0] dmaOut;

  modport master (output dmaEnable, dmaRW, dmaAddr, input dmaOut);
  modport slave  (input dmaEnable, dmaRW, dmaAddr, output dmaOut);
endinterface

// File: rtl/load_block_2d.sv
// Block loader: fetches a linear run or a 2D strided window through wide DMA read beats
// into a local buffer that consumers read through a combinational random-access port.
module load_block_2d #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int BEAT_WORDS = 25,
  parameter int BUF_DEPTH  = 1024,
  parameter int DMA_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  input  logic [ADDR_W-1:0]            address,
  input  logic [ADDR_W-1:0]            size,
  input  logic [ADDR_W-1:0]            rowLen,
  input  logic [ADDR_W-1:0]            numRows,
  input  logic [ADDR_W-1:0]            rowStride,
  load_block_2d_if.master              dma,
  input  logic [$clog2(BUF_DEPTH)-1:0] rdAddr,
  output logic [DATA_W-1:0]            rdData,
  output logic [ADDR_W-1:0]            count,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int TOT_W = 2 * ADDR_W;
  localparam int LAT_W = $clog2(DMA_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] row_len;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col;
  logic [TOT_W-1:0]  total;
  logic [PTR_W-1:0]  wptr;
  logic [LAT_W-1:0]  lat_cnt;
  logic              err_pend;

  logic [DATA_W-1:0] mem [BUF_DEPTH];

  logic [ADDR_W-1:0] rem;
  logic [ADDR_W-1:0] n;
  logic              row_end;
  logic [ADDR_W-1:0] count_nxt;
  logic              last;
  logic              cap;
  logic [TOT_W-1:0]  req_total;
  logic              bad;

  // Beat sizing, completion tests and start-time request validation.
  always_comb begin
    rem       = row_len - col;
    n         = ADDR_W'(BEAT_WORDS);
    row_end   = 1'b0;
    if (rem < ADDR_W'(BEAT_WORDS)) begin
      n       = rem;
      row_end = 1'b1;
    end else begin
      n       = ADDR_W'(BEAT_WORDS);
      row_end = (rem == ADDR_W'(BEAT_WORDS));
    end
    count_nxt = count + n;
    last      = (TOT_W'(count_nxt) == total);
    cap       = (state == S_WAIT) && enable && (lat_cnt == LAT_W'(DMA_LAT - 1));
    if (mode) begin
      req_total = TOT_W'(rowLen) * TOT_W'(numRows);
    end else begin
      req_total = TOT_W'(size);
    end
    bad = (req_total == {TOT_W{1'b0}}) || (req_total > TOT_W'(BUF_DEPTH));
  end

  // Transfer sequencer; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      dma.dmaEnable <= 1'b0;
      dma.dmaRW     <= 1'b0;
      dma.dmaAddr   <= {ADDR_W{1'b0}};
      count         <= {ADDR_W{1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_pend      <= 1'b0;
      row_len       <= {ADDR_W{1'b0}};
      stride        <= {ADDR_W{1'b0}};
      row_base      <= {ADDR_W{1'b0}};
      col           <= {ADDR_W{1'b0}};
      total         <= {TOT_W{1'b0}};
      wptr          <= {PTR_W{1'b0}};
      lat_cnt       <= {LAT_W{1'b0}};
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (enable) begin
            if (bad) begin
              err_pend <= 1'b1;
              state    <= S_DONE;
            end else begin
              // Linear mode is one row of length size; the stride is never used.
              err_pend      <= 1'b0;
              total         <= req_total;
              row_len       <= mode ? rowLen : size;
              stride        <= mode ? rowStride : {ADDR_W{1'b0}};
              row_base      <= address;
              col           <= {ADDR_W{1'b0}};
              wptr          <= {PTR_W{1'b0}};
              count         <= {ADDR_W{1'b0}};
              dma.dmaAddr   <= address;
              dma.dmaEnable <= 1'b1;
              dma.dmaRW     <= 1'b1;
              busy          <= 1'b1;
              state         <= S_REQ;
            end
          end
        end
        S_REQ: begin
          dma.dmaEnable <= 1'b0;
          dma.dmaRW     <= 1'b0;
          lat_cnt       <= {LAT_W{1'b0}};
          if (!enable) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cap) begin
            wptr  <= wptr + PTR_W'(n);
            count <= count_nxt;
            if (row_end) begin
              col      <= {ADDR_W{1'b0}};
              row_base <= row_base + stride;
            end else begin
              col <= col + n;
            end
            if (last) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              dma.dmaAddr   <= row_end ? (row_base + stride) : (row_base + col + n);
              dma.dmaEnable <= 1'b1;
              dma.dmaRW     <= 1'b1;
              state         <= S_REQ;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        S_DONE: begin
          if (!enable) begin
            done  <= 1'b0;
            err   <= 1'b0;
            state <= S_IDLE;
          end else begin
            done <= 1'b1;
            err  <= err_pend;
          end
        end
        default: begin
          dma.dmaEnable <= 1'b0;
          dma.dmaRW     <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
          err           <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

  // Beat capture: all n valid words land in the buffer on the same edge; storage is not reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < BEAT_WORDS; i++) begin
        if (ADDR_W'(i) < n) begin
          mem[wptr + PTR_W'(i)] <= dma.dmaOut[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: tb/tb_load_block_2d.sv
// Self-checking bench: two loaders (DMA latency 1 and 3) run the same randomized and
// directed transfers and are compared against a beat-list model of the transfer rules.
module tb_load_block_2d;
  localparam int BW    = 25;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [15:0] address, size, row_len, num_rows, row_stride;
  logic [9:0]  rd_addr;

  logic [1:0]        busy_o, done_o, err_o;
  logic [1:0][15:0]  count_o, rd_o;
  logic [1:0]        den, drw;
  logic [1:0][15:0]  daddr;

  logic [15:0] dmem [65536];
  logic [15:0] exp_buf [2][DEPTH];
  logic [15:0] req_a [$];
  logic [15:0] req_b [$];
  int          rw_bad_a, rw_bad_b;
  int          n_checks, n_pass;

  load_block_2d_if #(.DATA_W(16), .ADDR_W(16), .BEAT_WORDS(BW)) dma_a ();
  load_block_2d_if #(.DATA_W(16), .ADDR_W(16), .BEAT_WORDS(BW)) dma_b ();

  load_block_2d #(.DATA_W(16), .ADDR_W(16), .BEAT_WORDS(BW), .BUF_DEPTH(DEPTH), .DMA_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .address(address), .size(size),
    .rowLen(row_len), .numRows(num_rows), .rowStride(row_stride), .dma(dma_a.master),
    .rdAddr(rd_addr), .rdData(rd_o[0]), .count(count_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .err(err_o[0]));

  load_block_2d #(.DATA_W(16), .ADDR_W(16), .BEAT_WORDS(BW), .BUF_DEPTH(DEPTH), .DMA_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .address(address), .size(size),
    .rowLen(row_len), .numRows(num_rows), .rowStride(row_stride), .dma(dma_b.master),
    .rdAddr(rd_addr), .rdData(rd_o[1]), .count(count_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .err(err_o[1]));

  assign den   = {dma_b.dmaEnable, dma_a.dmaEnable};
  assign drw   = {dma_b.dmaRW, dma_a.dmaRW};
  assign daddr = {dma_b.dmaAddr, dma_a.dmaAddr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMA models: data for a request becomes valid DMA_LAT cycles after the request cycle.
  logic        va = 1'b0;
  logic [15:0] aa;
  logic [2:0]  vb = 3'b000;
  logic [15:0] ab [3];

  always @(posedge clk) begin
    va <= dma_a.dmaEnable;
    aa <= dma_a.dmaAddr;
    if (dma_a.dmaEnable === 1'b1) begin
      req_a.push_back(dma_a.dmaAddr);
      if (dma_a.dmaRW !== 1'b1) rw_bad_a++;
    end
  end

  always @(posedge clk) begin
    vb    <= {vb[1:0], dma_b.dmaEnable === 1'b1};
    ab[0] <= dma_b.dmaAddr;
    ab[1] <= ab[0];
    ab[2] <= ab[1];
    if (dma_b.dmaEnable === 1'b1) begin
      req_b.push_back(dma_b.dmaAddr);
      if (dma_b.dmaRW !== 1'b1) rw_bad_b++;
    end
  end

  always_comb begin
    dma_a.dmaOut = '0;
    dma_b.dmaOut = '0;
    for (int i = 0; i < BW; i++) begin
      dma_a.dmaOut[i*16 +: 16] = va    ? dmem[16'(aa + 16'(i))]    : 16'hDEAD;
      dma_b.dmaOut[i*16 +: 16] = vb[2] ? dmem[16'(ab[2] + 16'(i))] : 16'hDEAD;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // drop_at: 0 = run to completion, >0 = edge (after start) that samples enable=0, -1 = random drop.
  task automatic run_xfer(input string tag, input bit md, input logic [15:0] ad, sz, rl, nr, st,
                          input int drop_at);
    logic [15:0] baddr [$];
    int          bn [$];
    longint      total;
    int          rl_e, nr_e, st_e, beats, last_edge, lat, ncap, nreq, exp_done, cnt, wp, rsz;
    int          first [2];
    bit          exp_err;
    logic [15:0] got_a;
    if (md) begin rl_e = rl; nr_e = nr; st_e = st; end
    else    begin rl_e = sz; nr_e = 1;  st_e = 0;  end
    total   = longint'(rl_e) * longint'(nr_e);
    exp_err = (total == 0) || (total > DEPTH);
    if (!exp_err) begin
      for (int r = 0; r < nr_e; r++) begin
        for (int c = 0; c < rl_e; c += BW) begin
          baddr.push_back(16'(ad + r * st_e + c));
          bn.push_back((rl_e - c < BW) ? rl_e - c : BW);
        end
      end
    end
    beats = baddr.size();
    if (drop_at < 0) drop_at = (beats > 0) ? int'($urandom_range(2, 1 + beats * 2)) : 0;
    req_a.delete(); req_b.delete(); rw_bad_a = 0; rw_bad_b = 0;

    @(negedge clk);
    mode = md; address = ad; size = sz; row_len = rl; num_rows = nr; row_stride = st;
    enable = 1'b1;
    @(posedge clk);
    first = '{-1, -1};
    last_edge = (drop_at > 0) ? drop_at + 6 : 1 + beats * 4 + 3;
    for (int k = 1; k <= last_edge; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (done_o[i] === 1'b1 && first[i] < 0) first[i] = k;
      if (k == drop_at - 1) enable = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      ncap = beats; nreq = beats;
      exp_done = exp_err ? 1 : 1 + beats * (1 + lat);
      if (drop_at > 0) begin
        ncap = 0; nreq = 0;
        for (int j = 1; j <= beats; j++) begin
          if (j * (1 + lat) < drop_at) ncap++;
          if ((j - 1) * (1 + lat) < drop_at) nreq++;
        end
        if (drop_at <= exp_done) exp_done = -1;
      end
      check($sformatf("%s done_edge dut%0d", tag, i), first[i], exp_done);
      check($sformatf("%s err dut%0d", tag, i), err_o[i], (drop_at == 0) ? exp_err : 1'b0);
      check($sformatf("%s busy dut%0d", tag, i), busy_o[i], 1'b0);
      if (!exp_err) begin
        cnt = 0;
        for (int j = 0; j < ncap; j++) cnt += bn[j];
        check($sformatf("%s count dut%0d", tag, i), count_o[i], cnt);
      end
      rsz = (i == 0) ? req_a.size() : req_b.size();
      check($sformatf("%s n_req dut%0d", tag, i), rsz, nreq);
      for (int j = 0; j < rsz && j < nreq; j++) begin
        got_a = (i == 0) ? req_a[j] : req_b[j];
        check($sformatf("%s req_addr[%0d] dut%0d", tag, j, i), got_a, baddr[j]);
      end
      check($sformatf("%s dmaRW dut%0d", tag, i), (i == 0) ? rw_bad_a : rw_bad_b, 0);
      wp = 0;
      for (int j = 0; j < ncap; j++) begin
        for (int w = 0; w < bn[j]; w++) begin
          exp_buf[i][wp] = dmem[16'(baddr[j] + w)];
          wp++;
        end
      end
    end

    if (drop_at == 0) begin
      enable = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("%s done_clear dut%0d", tag, i), done_o[i], 1'b0);
        check($sformatf("%s err_clear dut%0d", tag, i), err_o[i], 1'b0);
      end
    end

    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 10'(a);
      #1;
      for (int i = 0; i < 2; i++)
        check($sformatf("%s buf[%0d] dut%0d", tag, a, i), rd_o[i], exp_buf[i][a]);
    end
  endtask

  initial begin
    logic [15:0] r_rl, r_nr;
    n_checks = 0; n_pass = 0;
    reset = 1'b0; enable = 1'b0; mode = 1'b0; rd_addr = 10'd0;
    address = 16'd0; size = 16'd0; row_len = 16'd0; num_rows = 16'd0; row_stride = 16'd0;
    for (int a = 0; a < 65536; a++) dmem[a] = 16'($urandom);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset dmaEnable dut%0d", i), den[i], 1'b0);
      check($sformatf("reset dmaRW dut%0d", i), drw[i], 1'b0);
      check($sformatf("reset dmaAddr dut%0d", i), daddr[i], 16'd0);
      check($sformatf("reset count dut%0d", i), count_o[i], 16'd0);
      check($sformatf("reset busy dut%0d", i), busy_o[i], 1'b0);
      check($sformatf("reset done dut%0d", i), done_o[i], 1'b0);
      check($sformatf("reset err dut%0d", i), err_o[i], 1'b0);
    end
    reset = 1'b1;

    run_xfer("fill1024",  1'b0, 16'd1000,  16'd1024, 16'd0,  16'd0,  16'd0,  0);
    run_xfer("lin50",     1'b0, 16'd500,   16'd50,   16'd0,  16'd0,  16'd0,  0);
    run_xfer("lin30",     1'b0, 16'd3000,  16'd30,   16'd0,  16'd0,  16'd0,  0);
    run_xfer("win5x5",    1'b1, 16'd0,     16'd0,    16'd5,  16'd5,  16'd10, 0);
    run_xfer("size0",     1'b0, 16'd77,    16'd0,    16'd0,  16'd0,  16'd0,  0);
    run_xfer("win40x40",  1'b1, 16'd0,     16'd0,    16'd40, 16'd40, 16'd40, 0);
    run_xfer("size1025",  1'b0, 16'd9,     16'd1025, 16'd0,  16'd0,  16'd0,  0);
    run_xfer("lin25",     1'b0, 16'd123,   16'd25,   16'd0,  16'd0,  16'd0,  0);
    run_xfer("abort75",   1'b0, 16'd4000,  16'd75,   16'd0,  16'd0,  16'd0,  4);
    run_xfer("wrap2d",    1'b1, 16'hFFF0,  16'd0,    16'd30, 16'd3,  16'h8000, 0);

    for (int t = 0; t < 12; t++) begin
      r_rl = 16'($urandom_range(1, 60));
      r_nr = 16'($urandom_range(1, 1100 / r_rl));
      run_xfer($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 16'($urandom),
               16'($urandom_range(0, 1100)), r_rl, r_nr, 16'($urandom_range(0, 300)),
               ($urandom_range(0, 3) == 0) ? -1 : 0);
    end

    @(negedge clk);
    mode = 1'b0; address = 16'd7; size = 16'd50; enable = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("midreq dmaEnable dut%0d", i), den[i], 1'b1);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst dmaEnable dut%0d", i), den[i], 1'b0);
      check($sformatf("rst dmaAddr dut%0d", i), daddr[i], 16'd0);
      check($sformatf("rst busy dut%0d", i), busy_o[i], 1'b0);
      check($sformatf("rst count dut%0d", i), count_o[i], 16'd0);
    end
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/load_block_2d.md
Name: load_block_2d

Overview:
- Parametrised successor to the single-mode block loader.
- Reads a linear run or a 2D strided window of words through the DMA's wide read beat into an internal buffer.
- The conv layer and other consumers read the buffer through a random-access port.
- Adds 2D mode, partial-beat handling, configurable DMA latency, size-error detection and a loaded-word count.

Parameters:
- DATA_W, 16, word width.
- ADDR_W, 16, DMA address / size field width.
- BEAT_WORDS, 25, words returned per DMA read beat.
- BUF_DEPTH, 1024, buffer depth in words (power of 2).
- DMA_LAT, 1, cycles from the request cycle to valid dmaOut (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level start; held high for the whole transfer.
- mode  in  1  0 = linear, 1 = 2D window.
- address  in  ADDR_W  start address in DMA space.
- size  in  ADDR_W  word count, linear mode.
- rowLen  in  ADDR_W  words per row, 2D mode.
- numRows  in  ADDR_W  row count, 2D mode.
- rowStride  in  ADDR_W  address step between row starts, 2D mode.
- dmaEnable  out  1  read request, one cycle per beat.
- dmaRW  out  1  1 whenever dmaEnable is high (read).
- dmaAddr  out  ADDR_W  beat address.
- dmaOut  in  DATA_W*BEAT_WORDS  beat data; word i is at bits [i*DATA_W +: DATA_W].
- rdAddr  in  log2(BUF_DEPTH)  buffer read address.
- rdData  out  DATA_W  buffer[rdAddr], combinational.
- count  out  ADDR_W  words stored so far.
- busy  out  1  high in REQ/WAIT.
- done  out  1  level; transfer finished.
- err  out  1  level; request rejected.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; dmaEnable, dmaRW, done, err, busy = 0; dmaAddr, count = 0.
  - Buffer contents are not reset.
- Configuration inputs are sampled only on the IDLE->start edge and held internally.
- Total words:
  - linear: size.
  - 2D: rowLen*numRows, computed at 2*ADDR_W width.
- IDLE:
  - enable=1 with total==0 or total>BUF_DEPTH -> DONE with err=1; no DMA request is issued.
  - Otherwise -> REQ with wptr=0, row=0, col=0, count=0.
- REQ (1 cycle):
  - dmaEnable=1, dmaRW=1.
  - dmaAddr = rowBase+col, where rowBase = address + row*rowStride, truncated to ADDR_W.
  - In linear mode the whole transfer is treated as one row of length size.
  - -> WAIT.
- WAIT (DMA_LAT cycles):
  - dmaEnable=0.
  - On the edge ending the DMA_LAT-th WAIT cycle, n = min(BEAT_WORDS, rowRemaining) words are captured: words 0..n-1 go to buffer[wptr..wptr+n-1]. All n are written in that single edge.
  - wptr, count and col advance by n.
  - If the row is complete: col=0, row++.
  - Next state is REQ if words remain, else DONE.
- Beats never span two rows; a row tail produces a partial beat and unused beat words are discarded.
- Timing: per-beat cost is 1+DMA_LAT cycles. done rises (1 + beats*(1+DMA_LAT)) edges after the edge that samples enable=1.
- DONE:
  - done=1 (and err as set) while enable=1.
  - enable=0 -> IDLE; done and err clear on that edge.
  - count holds its final value until the next start.
- enable dropped while busy: the transfer is aborted at the next edge.
  - In REQ or WAIT -> IDLE; data in flight is ignored; done stays 0.
  - Buffer keeps the words already written; count shows them.
- Buffer read port:
  - rdData reflects the buffer state before the current edge.
  - A same-cycle read of an address being written returns the old value.
  - rdAddr is unrestricted at all times.
- Address arithmetic wraps modulo 2^ADDR_W; no error is raised.
- Reset asserted mid-transfer: immediate IDLE with all outputs at reset values.

Test Plan:
- Linear, size=50, address=500, DMA_LAT=1 -> dmaAddr 500 then 525, each with a 1-cycle dmaEnable. done at edge 5 after start; count=50; rdAddr 0..49 matches mem[500..549].
- Linear, size=30 -> two beats (25 + 5). Beat-2 words 5..24 are discarded; buffer[30] is unchanged from its prior value; count=30.
- 2D, address=0, rowLen=5, numRows=5, rowStride=10 -> dmaAddr 0,10,20,30,40; buffer[5r+c] = mem[10r+c]; done at edge 11.
- size=0, and separately 2D 40x40 (1600 > 1024) -> done=1, err=1 on the edge after start; dmaEnable never asserts; both clear after enable=0.
- DMA_LAT=3, size=25 -> dmaEnable high 1 cycle, capture 3 edges later, done at edge 5.
- enable dropped in WAIT of beat 2 (size=75) -> IDLE, count=25, no done. Reset pulsed mid-REQ -> dmaEnable drops asynchronously.
